// File: rtl/pio_pkg.sv
// Shared constants for the PIO edge-capture block: register word addresses,
// edge-type encodings and the edge qualification helper.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

  // Unsupported encodings never report an edge.
  function automatic logic edge_match(input edge_type_e etype, input logic cur, input logic prev);
    logic hit;
    hit = 1'b0;
    case (etype)
      EDGE_RISING:  hit = cur & ~prev;
      EDGE_FALLING: hit = ~cur & prev;
      EDGE_ANY:     hit = cur ^ prev;
      default:      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pio_in_channel.sv
// One input channel: metastability synchroniser, optional debounce filter
// and edge detector against the previous debounced value.
module pio_in_channel
  import pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic                   deb_s;
  logic                   prev_r;

  // Synchroniser shift chain; din is asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      assign deb_s = sync_s;
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt_r;
      logic          deb_r;

      // Accept a new level only after it has been seen on consecutive samples.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_r <= '0;
          deb_r <= 1'b0;
        end else if (sync_s == deb_r) begin
          cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
          deb_r <= sync_s;
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end

      assign deb_s = deb_r;
    end
  endgenerate

  // Previous debounced value for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= deb_s;
    end
  end

  assign level    = deb_s;
  assign edge_det = edge_match(edge_type_e'(EDGE_TYPE), deb_s, prev_r);

endmodule

// File: rtl/pio_edge_capture.sv
// Avalon-MM PIO input block with per-channel edge capture, interrupt mask
// and a registered level interrupt.
module pio_edge_capture
  import pio_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] data_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] edgecap_r;
  logic [WIDTH-1:0] mask_nxt_s;
  logic [WIDTH-1:0] edgecap_nxt_s;
  logic [WIDTH-1:0] clr_s;
  logic [31:0]      rd_s;
  logic             wr_en_s;
  logic             unused_wdata_s;

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      pio_in_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .EDGE_TYPE      (EDGE_TYPE)
      ) u_ch (
        .clk     (clk),
        .reset   (reset),
        .din     (in_port[g]),
        .level   (data_s[g]),
        .edge_det(edge_s[g])
      );
    end
  endgenerate

  assign wr_en_s        = chipselect & ~write_n;
  assign unused_wdata_s = ^writedata;

  // Register-file next state and read mux; a fresh edge beats a same-cycle clear.
  always_comb begin
    mask_nxt_s    = mask_r;
    clr_s         = '0;
    edgecap_nxt_s = edgecap_r;
    rd_s          = 32'd0;
    if (wr_en_s && (address == ADDR_IRQMASK)) begin
      mask_nxt_s = writedata[WIDTH-1:0];
    end else begin
      mask_nxt_s = mask_r;
    end
    if (wr_en_s && (address == ADDR_EDGECAP)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    edgecap_nxt_s = (edgecap_r & ~clr_s) | edge_s;
    case (address)
      ADDR_DATA:    rd_s[WIDTH-1:0] = data_s;
      ADDR_RSVD:    rd_s = 32'd0;
      ADDR_IRQMASK: rd_s[WIDTH-1:0] = mask_r;
      ADDR_EDGECAP: rd_s[WIDTH-1:0] = edgecap_r;
      default:      rd_s = 32'd0;
    endcase
  end

  // Register file, read data and interrupt state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_r    <= '0;
      edgecap_r <= '0;
      readdata  <= 32'd0;
      irq       <= 1'b0;
    end else begin
      mask_r    <= mask_nxt_s;
      edgecap_r <= edgecap_nxt_s;
      readdata  <= rd_s;
      irq       <= |(edgecap_r & mask_r);
    end
  end

endmodule
